// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the MEM-stage matrix/scalar port sequencer.
package mem_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } seq_state_e;

    localparam logic [1:0] BYTE_SEL_WORD = 2'b10;
    localparam int         MX_WORDS_DEF  = 4;
    localparam int         WORD_BYTES    = 4;

endpackage

// File: rtl/mem_matrix_seq_if.sv
// Bus bundle between the pipeline, the matrix unit, the sequencer and the data memory.
// slave = sequencer side, master = pipeline/matrix/memory side.
interface mem_matrix_seq_if
    import mem_seq_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int MX_WORDS = MX_WORDS_DEF
);
    logic [ADDR_W-1:0]       sc_addr;
    logic [31:0]             sc_wdata;
    logic                    sc_r_en;
    logic                    sc_w_en;
    logic [1:0]              sc_byte_sel;
    logic [31:0]             sc_rdata;

    logic                    mx_req_valid;
    logic                    mx_req_ready;
    logic                    mx_req_write;
    logic [ADDR_W-1:0]       mx_base_addr;
    logic [MX_WORDS*32-1:0]  mx_wdata;
    logic [MX_WORDS*32-1:0]  mx_rdata;
    logic                    mx_done;
    logic                    stall;

    logic [ADDR_W-1:0]       mem_addr;
    logic [31:0]             mem_wdata;
    logic                    mem_r_en;
    logic                    mem_w_en;
    logic [1:0]              mem_byte_sel;
    logic [31:0]             mem_rdata;

    modport slave (
        input  sc_addr, sc_wdata, sc_r_en, sc_w_en, sc_byte_sel,
        output sc_rdata,
        input  mx_req_valid, mx_req_write, mx_base_addr, mx_wdata,
        output mx_req_ready, mx_rdata, mx_done, stall,
        output mem_addr, mem_wdata, mem_r_en, mem_w_en, mem_byte_sel,
        input  mem_rdata
    );

    modport master (
        output sc_addr, sc_wdata, sc_r_en, sc_w_en, sc_byte_sel,
        input  sc_rdata,
        output mx_req_valid, mx_req_write, mx_base_addr, mx_wdata,
        input  mx_req_ready, mx_rdata, mx_done, stall,
        input  mem_addr, mem_wdata, mem_r_en, mem_w_en, mem_byte_sel,
        output mem_rdata
    );

endinterface

// File: rtl/mem_port_mux.sv
// Steers the single data-memory port between the scalar path and the burst engine;
// scalar read data and enables are blanked whenever the sequencer is not idle.
module mem_port_mux
    import mem_seq_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  seq_state_e         state,
    input  logic [ADDR_W-1:0]  burst_addr,
    input  logic [31:0]        burst_wdata,
    input  logic               burst_write,
    input  logic [ADDR_W-1:0]  sc_addr,
    input  logic [31:0]        sc_wdata,
    input  logic               sc_r_en,
    input  logic               sc_w_en,
    input  logic [1:0]         sc_byte_sel,
    input  logic [31:0]        mem_rdata,
    output logic [31:0]        sc_rdata,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [31:0]        mem_wdata,
    output logic               mem_r_en,
    output logic               mem_w_en,
    output logic [1:0]         mem_byte_sel
);

    always_comb begin
        mem_addr     = sc_addr;
        mem_wdata    = sc_wdata;
        mem_r_en     = sc_r_en;
        mem_w_en     = sc_w_en;
        mem_byte_sel = sc_byte_sel;
        sc_rdata     = mem_rdata;
        if (state != IDLE) begin
            // DONE keeps the burst address on the bus but leaves the port quiet
            sc_rdata     = '0;
            mem_addr     = burst_addr;
            mem_wdata    = burst_wdata;
            mem_byte_sel = BYTE_SEL_WORD;
            mem_r_en     = (state == BURST) && !burst_write;
            mem_w_en     = (state == BURST) &&  burst_write;
        end
    end

endmodule

// File: rtl/mem_matrix_seq.sv
// MEM-stage port sequencer: splits matrix row load/store into word beats and stalls the pipeline.
// Optional MEM_SEQ_PERF_EN adds saturating burst-beat and stall-cycle counters.
module mem_matrix_seq
    import mem_seq_pkg::*;
#(
    parameter int MX_WORDS = MX_WORDS_DEF,
    parameter int ADDR_W   = 32,
    parameter int CNT_W    = $clog2(MX_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    mem_matrix_seq_if.slave   bus
`ifdef MEM_SEQ_PERF_EN
    ,
    output logic [31:0]       perf_beats,
    output logic [31:0]       perf_stall
`endif
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MX_WORDS - 1);

    seq_state_e              state_reg;
    logic [CNT_W-1:0]        beat_reg;
    logic [ADDR_W-1:0]       base_reg;
    logic [MX_WORDS*32-1:0]  wdata_reg;
    logic                    write_reg;
    logic                    done_reg;

    logic [ADDR_W-1:0]       burst_addr;
    logic [31:0]             burst_wdata;
    logic                    load_beat;

    assign bus.mx_req_ready = (state_reg == IDLE) && !bus.sc_r_en && !bus.sc_w_en;
    assign bus.stall        = (state_reg != IDLE);
    assign bus.mx_done      = done_reg;

    // Address arithmetic wraps modulo 2^ADDR_W by construction
    assign burst_addr  = base_reg + ADDR_W'(beat_reg) * ADDR_W'(WORD_BYTES);
    assign burst_wdata = wdata_reg[{beat_reg, 5'b00000} +: 32];
    assign load_beat   = (state_reg == BURST) && !write_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            beat_reg  <= '0;
            base_reg  <= '0;
            wdata_reg <= '0;
            write_reg <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.mx_req_valid && bus.mx_req_ready) begin
                        base_reg  <= bus.mx_base_addr & ~ADDR_W'(3);
                        wdata_reg <= bus.mx_wdata;
                        write_reg <= bus.mx_req_write;
                        beat_reg  <= '0;
                        state_reg <= BURST;
                    end
                end
                BURST: begin
                    if (beat_reg == LAST_BEAT) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end else begin
                        beat_reg <= beat_reg + 1'b1;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // One capture register per row word; a store burst never touches them
    generate
        for (genvar gi = 0; gi < MX_WORDS; gi++) begin : g_word
            logic [31:0] word_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    word_reg <= '0;
                end else if (load_beat && (beat_reg == CNT_W'(gi))) begin
                    word_reg <= bus.mem_rdata;
                end
            end

            assign bus.mx_rdata[32*gi +: 32] = word_reg;
        end
    endgenerate

    mem_port_mux #(
        .ADDR_W (ADDR_W)
    ) u_mux (
        .state        (state_reg),
        .burst_addr   (burst_addr),
        .burst_wdata  (burst_wdata),
        .burst_write  (write_reg),
        .sc_addr      (bus.sc_addr),
        .sc_wdata     (bus.sc_wdata),
        .sc_r_en      (bus.sc_r_en),
        .sc_w_en      (bus.sc_w_en),
        .sc_byte_sel  (bus.sc_byte_sel),
        .mem_rdata    (bus.mem_rdata),
        .sc_rdata     (bus.sc_rdata),
        .mem_addr     (bus.mem_addr),
        .mem_wdata    (bus.mem_wdata),
        .mem_r_en     (bus.mem_r_en),
        .mem_w_en     (bus.mem_w_en),
        .mem_byte_sel (bus.mem_byte_sel)
    );

`ifdef MEM_SEQ_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_beats <= '0;
            perf_stall <= '0;
        end else begin
            if ((state_reg == BURST) && (perf_beats != '1)) begin
                perf_beats <= perf_beats + 1'b1;
            end
            if (bus.stall && (perf_stall != '1)) begin
                perf_stall <= perf_stall + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_matrix_seq.sv
// Self-checking bench for mem_matrix_seq: word-addressed memory model plus expected row image.
module tb_mem_matrix_seq;

    logic clk;
    logic rst;

    mem_matrix_seq_if #(.ADDR_W(32), .MX_WORDS(4)) bus ();

`ifdef MEM_SEQ_PERF_EN
    logic [31:0] perf_beats;
    logic [31:0] perf_stall;
`endif

    mem_matrix_seq #(
        .MX_WORDS (4),
        .ADDR_W   (32),
        .CNT_W    (2)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus)
`ifdef MEM_SEQ_PERF_EN
        ,
        .perf_beats (perf_beats),
        .perf_stall (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors;
    int          miscompares;
    bit [127:0]  exp_rdata;

    // Data memory: unwritten locations return an address-derived pattern
    bit [31:0]   mem [bit [31:0]];
    int unsigned mem_gen;

    function automatic bit [31:0] rd(input bit [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hC0DE_0000;
    endfunction

    always @(bus.mem_addr, mem_gen) bus.mem_rdata = rd(bus.mem_addr);

    always @(posedge clk) begin
        if (bus.mem_w_en === 1'b1) begin
            mem[bus.mem_addr] = bus.mem_wdata;
            mem_gen++;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.sc_addr      = '0;
        bus.sc_wdata     = '0;
        bus.sc_r_en      = 1'b0;
        bus.sc_w_en      = 1'b0;
        bus.sc_byte_sel  = 2'b00;
        bus.mx_req_valid = 1'b0;
        bus.mx_req_write = 1'b0;
        bus.mx_base_addr = '0;
        bus.mx_wdata     = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        #12;
        @(negedge clk);
        vectors++;
        if (bus.stall !== 1'b0 || bus.mx_done !== 1'b0 || bus.mx_rdata !== 128'h0 ||
            bus.mx_req_ready !== 1'b1 || bus.mem_r_en !== 1'b0 || bus.mem_w_en !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: stall=%b done=%b rdata=%h ready=%b ren=%b wen=%b required 0/0/0/1/0/0",
                     bus.stall, bus.mx_done, bus.mx_rdata, bus.mx_req_ready, bus.mem_r_en, bus.mem_w_en);
        end
        next_cycle();
        rst = 1'b1;
        next_cycle();
        exp_rdata = '0;
    endtask

    task automatic test_scalar();
        int op;
        bit [31:0] a;
        mem[32'h40] = 32'h0000_1234;
        bus.sc_addr = 32'h40;
        bus.sc_r_en = 1'b1;
        bus.sc_byte_sel = 2'b10;
        @(negedge clk);
        vectors++;
        if (bus.mem_addr !== 32'h40 || bus.sc_rdata !== 32'h1234 || bus.stall !== 1'b0 || bus.mx_req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL scalar_fixed: addr=%h rdata=%h stall=%b ready=%b required 00000040/00001234/0/0",
                     bus.mem_addr, bus.sc_rdata, bus.stall, bus.mx_req_ready);
        end
        next_cycle();
        for (int k = 0; k < 10; k++) begin
            op = int'($urandom_range(0, 2));
            a = $urandom;
            bus.sc_addr     = a;
            bus.sc_wdata    = $urandom;
            bus.sc_byte_sel = 2'($urandom_range(0, 3));
            bus.sc_r_en     = (op == 1);
            bus.sc_w_en     = (op == 2);
            @(negedge clk);
            vectors++;
            if (bus.mem_addr !== a || bus.mem_wdata !== bus.sc_wdata || bus.mem_r_en !== (op == 1) ||
                bus.mem_w_en !== (op == 2) || bus.mem_byte_sel !== bus.sc_byte_sel ||
                bus.sc_rdata !== rd(a) || bus.stall !== 1'b0 || bus.mx_req_ready !== (op == 0)) begin
                miscompares++;
                $display("FAIL scalar_rand op=%0d: addr=%h ren=%b wen=%b sel=%b rdata=%h ready=%b required addr=%h rdata=%h ready=%b",
                         op, bus.mem_addr, bus.mem_r_en, bus.mem_w_en, bus.mem_byte_sel, bus.sc_rdata,
                         bus.mx_req_ready, a, rd(a), (op == 0));
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    // Issues one row request in an IDLE cycle and follows it to completion
    task automatic run_row(input bit wr, input bit [31:0] base, input bit [127:0] wd,
                           input bit hold, input bit junk, input string tag);
        bit [31:0] a;
        bus.sc_r_en      = 1'b0;
        bus.sc_w_en      = 1'b0;
        bus.mx_req_valid = 1'b1;
        bus.mx_req_write = wr;
        bus.mx_base_addr = base;
        bus.mx_wdata     = wd;
        @(negedge clk);
        vectors++;
        if (bus.mx_req_ready !== 1'b1 || bus.stall !== 1'b0) begin
            miscompares++;
            $display("FAIL %s accept: ready=%b stall=%b required ready=1 stall=0", tag, bus.mx_req_ready, bus.stall);
        end
        next_cycle();
        bus.mx_req_valid = hold;
        bus.mx_req_write = ~wr;
        bus.mx_base_addr = $urandom;
        bus.mx_wdata     = {$urandom, $urandom, $urandom, $urandom};
        if (junk) begin
            bus.sc_r_en = 1'b1;
            bus.sc_w_en = 1'($urandom_range(0, 1));
            bus.sc_addr = $urandom;
        end
        for (int i = 0; i < 4; i++) begin
            a = (base & ~32'h3) + 32'(i * 4);
            @(negedge clk);
            vectors++;
            if (bus.mem_addr !== a || bus.mem_byte_sel !== 2'b10 || bus.mem_w_en !== wr ||
                bus.mem_r_en !== !wr || bus.stall !== 1'b1 || bus.mx_req_ready !== 1'b0 ||
                bus.mx_done !== 1'b0 || bus.sc_rdata !== 32'h0) begin
                miscompares++;
                $display("FAIL %s beat%0d: addr=%h sel=%b ren=%b wen=%b stall=%b ready=%b done=%b sc_rdata=%h required addr=%h wen=%b",
                         tag, i, bus.mem_addr, bus.mem_byte_sel, bus.mem_r_en, bus.mem_w_en, bus.stall,
                         bus.mx_req_ready, bus.mx_done, bus.sc_rdata, a, wr);
            end
            if (wr) begin
                vectors++;
                if (bus.mem_wdata !== wd[32*i +: 32]) begin
                    miscompares++;
                    $display("FAIL %s wdata%0d: got %h required %h", tag, i, bus.mem_wdata, wd[32*i +: 32]);
                end
            end else begin
                exp_rdata[32*i +: 32] = rd(a);
            end
            next_cycle();
        end
        @(negedge clk);
        vectors++;
        if (bus.mx_done !== 1'b1 || bus.stall !== 1'b1 || bus.mem_r_en !== 1'b0 ||
            bus.mem_w_en !== 1'b0 || bus.mx_req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL %s done_cycle: done=%b stall=%b ren=%b wen=%b ready=%b required 1/1/0/0/0",
                     tag, bus.mx_done, bus.stall, bus.mem_r_en, bus.mem_w_en, bus.mx_req_ready);
        end
        next_cycle();
        bus.mx_req_valid = 1'b0;
        bus.sc_r_en      = 1'b0;
        bus.sc_w_en      = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.mx_done !== 1'b0 || bus.stall !== 1'b0 || bus.mx_rdata !== exp_rdata) begin
            miscompares++;
            $display("FAIL %s after: done=%b stall=%b rdata=%h required done=0 stall=0 rdata=%h",
                     tag, bus.mx_done, bus.stall, bus.mx_rdata, exp_rdata);
        end
        if (wr) begin
            for (int i = 0; i < 4; i++) begin
                a = (base & ~32'h3) + 32'(i * 4);
                vectors++;
                if (rd(a) !== wd[32*i +: 32]) begin
                    miscompares++;
                    $display("FAIL %s mem%0d @%h: got %h required %h", tag, i, a, rd(a), wd[32*i +: 32]);
                end
            end
        end
        next_cycle();
    endtask

    task automatic test_row_store();
        run_row(1'b1, 32'h100, {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001}, 1'b0, 1'b0, "row_store");
    endtask

    task automatic test_row_load();
        mem[32'h200] = 32'h11;
        mem[32'h204] = 32'h22;
        mem[32'h208] = 32'h33;
        mem[32'h20C] = 32'h44;
        run_row(1'b0, 32'h203, '0, 1'b0, 1'b0, "row_load");
        vectors++;
        if (bus.mx_rdata !== {32'h44, 32'h33, 32'h22, 32'h11}) begin
            miscompares++;
            $display("FAIL row_load_value: got %h required %h", bus.mx_rdata, {32'h44, 32'h33, 32'h22, 32'h11});
        end
    endtask

    task automatic test_conflict();
        bus.sc_w_en      = 1'b1;
        bus.sc_addr      = 32'h500;
        bus.sc_wdata     = 32'h5A5A_1234;
        bus.mx_req_valid = 1'b1;
        bus.mx_req_write = 1'b0;
        bus.mx_base_addr = 32'h600;
        @(negedge clk);
        vectors++;
        if (bus.mx_req_ready !== 1'b0 || bus.mem_w_en !== 1'b1 || bus.mem_addr !== 32'h500 || bus.stall !== 1'b0) begin
            miscompares++;
            $display("FAIL conflict: ready=%b wen=%b addr=%h stall=%b required 0/1/00000500/0",
                     bus.mx_req_ready, bus.mem_w_en, bus.mem_addr, bus.stall);
        end
        next_cycle();
        bus.sc_w_en = 1'b0;
        run_row(1'b0, 32'h600, '0, 1'b0, 1'b0, "conflict_row");
        vectors++;
        if (rd(32'h500) !== 32'h5A5A_1234) begin
            miscompares++;
            $display("FAIL conflict_scalar_write: got %h required 5a5a1234", rd(32'h500));
        end
    endtask

    task automatic test_wrap();
        run_row(1'b0, 32'hFFFF_FFF8, '0, 1'b0, 1'b0, "wrap_load");
        run_row(1'b1, 32'hFFFF_FFFA, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, "wrap_store");
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) begin
            run_row(1'($urandom_range(0, 1)), $urandom, {$urandom, $urandom, $urandom, $urandom},
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand_row");
        end
    endtask

    task automatic test_reset_mid_burst();
        mem[32'h308] = 32'hDEAD_BEEF;
        mem[32'h30C] = 32'hFEED_F00D;
        bus.mx_req_valid = 1'b1;
        bus.mx_req_write = 1'b1;
        bus.mx_base_addr = 32'h300;
        bus.mx_wdata     = {32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
        next_cycle();
        bus.mx_req_valid = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.mem_w_en !== 1'b0 || bus.stall !== 1'b0 || bus.mx_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: wen=%b stall=%b done=%b required 0/0/0", bus.mem_w_en, bus.stall, bus.mx_done);
        end
        next_cycle();
        vectors++;
        if (rd(32'h300) !== 32'h1111_0001 || rd(32'h304) !== 32'h2222_0002 ||
            rd(32'h308) !== 32'hDEAD_BEEF || rd(32'h30C) !== 32'hFEED_F00D) begin
            miscompares++;
            $display("FAIL reset_mid_mem: %h %h %h %h required 11110001 22220002 deadbeef feedf00d",
                     rd(32'h300), rd(32'h304), rd(32'h308), rd(32'h30C));
        end
        rst = 1'b1;
        exp_rdata = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if (bus.mx_done !== 1'b0 || bus.stall !== 1'b0 || bus.mx_req_ready !== 1'b1 || bus.mx_rdata !== 128'h0) begin
                miscompares++;
                $display("FAIL reset_mid_idle%0d: done=%b stall=%b ready=%b rdata=%h required 0/0/1/0",
                         k, bus.mx_done, bus.stall, bus.mx_req_ready, bus.mx_rdata);
            end
            next_cycle();
        end
        run_row(1'b1, 32'h300, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, "post_reset_row");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        mem_gen     = 0;
        test_reset();
        test_scalar();
        test_row_store();
        test_row_load();
        test_conflict();
        test_wrap();
        test_back_to_back();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_matrix_seq.md
Name: mem_matrix_seq

Overview:
Sequencer/arbiter in front of the 32-bit single-port data memory in the MEM stage. It shares the port between the scalar pipeline access path (LW/SW/LB…) and 128-bit matrix row load/store requests (mst/mvtr class). A matrix request is split into MX_WORDS consecutive 32-bit word beats. The pipeline is stalled while a burst owns the port.
- Memory read is combinational: data for the address driven in cycle N is valid in cycle N.
- Memory write commits on the clk edge closing the cycle.

Parameters:
MX_WORDS, 4, words per matrix row; rows are MX_WORDS*32 bits wide
ADDR_W, 32, address width
CNT_W, 2, beat counter width, $clog2(MX_WORDS)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
sc_addr  in  ADDR_W  scalar access address
sc_wdata  in  32  scalar store data
sc_r_en  in  1  scalar read enable
sc_w_en  in  1  scalar write enable
sc_byte_sel  in  2  scalar size (func3[1:0])
sc_rdata  out  32  scalar read data
mx_req_valid  in  1  matrix request valid
mx_req_ready  out  1  matrix request accepted this cycle when valid & ready
mx_req_write  in  1  1 = store row, 0 = load row
mx_base_addr  in  ADDR_W  row base byte address
mx_wdata  in  MX_WORDS*32  row store data; word i at [32*i+31 -: 32]
mx_rdata  out  MX_WORDS*32  loaded row
mx_done  out  1  one-cycle completion pulse
stall  out  1  freeze upstream pipeline
mem_addr  out  ADDR_W  to data memory
mem_wdata  out  32  to data memory
mem_r_en  out  1  to data memory
mem_w_en  out  1  to data memory
mem_byte_sel  out  2  to data memory
mem_rdata  in  32  from data memory

Behaviour:
- Reset values: state IDLE, beat 0, mx_rdata 0, mx_done 0, stall 0, latched base/wdata/write 0.
- States:
  - IDLE: memory port = scalar inputs passed through; sc_rdata = mem_rdata.
  - mx_req_ready = IDLE & ~sc_r_en & ~sc_w_en. Scalar access wins over a same-cycle matrix request.
  - On accept: latch {base[ADDR_W-1:2], 2'b00} (base[1:0] ignored), mx_wdata and mx_req_write; beat <= 0; go to BURST.
  - BURST:
    - mem_addr = base + 4*beat, modulo 2^ADDR_W; wraps silently.
    - mem_byte_sel = 2'b10 (word).
    - Store beat: mem_w_en = 1, mem_r_en = 0, mem_wdata = word[beat].
    - Load beat: mem_r_en = 1, mem_w_en = 0; mx_rdata[beat] <= mem_rdata at the clock edge.
    - beat == MX_WORDS-1 → DONE; otherwise beat + 1.
  - DONE: mx_done = 1 for exactly one cycle; port idle (enables 0); go to IDLE.
- Outputs while not IDLE:
  - stall = (state != IDLE), combinational.
  - sc_rdata = 0; scalar enables are masked (never reach memory).
- Timing:
  - Request accepted in cycle T → beats in T+1..T+MX_WORDS.
  - mx_done in T+MX_WORDS+1; next accept possible at T+MX_WORDS+2.
  - The pipeline re-presents the stalled scalar access after stall drops.
- mx_rdata holds its value until the next load burst overwrites it word by word. A store burst leaves mx_rdata unchanged.
- mx_req_valid held high during a burst is ignored (ready = 0); it is accepted again only in IDLE.
- Reset asserted mid-burst: immediate return to IDLE, enables 0, no further beats, mx_done not pulsed.

Optional Feature:
- Macro MEM_SEQ_PERF_EN.
- Defined: adds outputs perf_beats (32) and perf_stall (32).
  - perf_beats increments on each BURST cycle; perf_stall increments on each stall cycle.
  - Both reset to 0 and saturate at all-ones.
- Undefined: neither the ports nor the counters exist; behaviour is otherwise identical.

Decomposition:
- Package mem_seq_pkg:
  - state enum {IDLE, BURST, DONE}
  - BYTE_SEL_WORD = 2'b10
  - MX_WORDS_DEF = 4
  - WORD_BYTES = 4
- One sub-module, mem_port_mux: combinational selection of scalar vs. burst drive onto the mem_* outputs, plus sc_rdata masking.
- FSM, beat counter and latches stay in the top module.

Test Plan:
- Scalar only: sc_r_en = 1, sc_addr = 0x40, mem_rdata = 0x1234 → mem_addr = 0x40, sc_rdata = 0x1234, stall = 0, mx_req_ready = 0.
- Row store: base 0x100, wdata {D,C,B,A}, accepted at T → T+1..T+4 writes A@0x100, B@0x104, C@0x108, D@0x10C with byte_sel 2'b10; mx_done at T+5; stall high T+1..T+5.
- Row load: base 0x203 (misaligned), memory returns 0x11/0x22/0x33/0x44 → reads 0x200..0x20C; mx_rdata = {0x44,0x33,0x22,0x11} after done.
- Conflict: sc_w_en = 1 and mx_req_valid = 1 in the same IDLE cycle → scalar write issued, ready = 0; matrix accepted next cycle after sc_w_en drops.
- Wrap: base 0xFFFFFFF8 → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
- Reset after the 2nd beat of a store → no 3rd write, mx_done stays 0, state IDLE, stall 0, next request accepted normally.
